// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : round-robin share of one in-order memory port between
//                    fetch and load/store, with owner FIFO response routing.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   imem_req_valid,
  input  logic [ADDR_W-1:0]                      imem_req_addr,
  output logic                                   imem_req_ready,
  output logic                                   imem_resp_valid,
  output logic [DATA_W-1:0]                      imem_resp_data,
  input  logic                                   imem_resp_ready,
  input  logic                                   dmem_req_valid,
  input  logic                                   dmem_req_we,
  input  logic [ADDR_W-1:0]                      dmem_req_addr,
  input  logic [DATA_W-1:0]                      dmem_req_wdata,
  input  logic [DATA_W/8-1:0]                    dmem_req_wstrb,
  output logic                                   dmem_req_ready,
  output logic                                   dmem_resp_valid,
  output logic [DATA_W-1:0]                      dmem_resp_data,
  input  logic                                   dmem_resp_ready,
  output logic                                   mem_req_valid,
  output logic                                   mem_req_we,
  output logic [ADDR_W-1:0]                      mem_req_addr,
  output logic [DATA_W-1:0]                      mem_req_wdata,
  output logic [DATA_W/8-1:0]                    mem_req_wstrb,
  input  logic                                   mem_req_ready,
  input  logic                                   mem_resp_valid,
  input  logic [DATA_W-1:0]                      mem_resp_data,
  output logic                                   mem_resp_ready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   err_resp
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic                       lock_sel_q, lock_sel_d;
  logic                       rr_last_q, rr_last_d;
  logic                       err_q, err_d;
  logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;

  logic w_sel;        // 0 = imem, 1 = dmem
  logic w_sel_valid;
  logic w_full;
  logic w_empty;
  logic w_req_valid;
  logic w_req_fire;
  logic w_head;
  logic w_resp_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_full  = (count_q == C_CNT_MAX);
    w_empty = (count_q == '0);
    if (state_q == ST_HOLD) begin
      w_sel = lock_sel_q;
    end else if (imem_req_valid && dmem_req_valid) begin
      w_sel = ~rr_last_q;
    end else begin
      w_sel = dmem_req_valid;
    end
    w_sel_valid = w_sel ? dmem_req_valid : imem_req_valid;
    // Full blocks on the registered count only, so a same-cycle pop cannot open the request path.
    w_req_valid = reset_n && !w_full && w_sel_valid;
    w_req_fire  = w_req_valid && mem_req_ready;
  end

  always_comb begin
    mem_req_valid  = w_req_valid;
    mem_req_we     = w_sel & dmem_req_we;
    mem_req_addr   = w_sel ? dmem_req_addr  : imem_req_addr;
    mem_req_wdata  = w_sel ? dmem_req_wdata : '0;
    mem_req_wstrb  = w_sel ? dmem_req_wstrb : '0;
    imem_req_ready = w_req_fire && !w_sel;
    dmem_req_ready = w_req_fire && w_sel;
  end

  always_comb begin
    w_head          = owner_q[rd_ptr_q];
    imem_resp_data  = mem_resp_data;
    dmem_resp_data  = mem_resp_data;
    imem_resp_valid = 1'b0;
    dmem_resp_valid = 1'b0;
    mem_resp_ready  = 1'b0;
    if (reset_n) begin
      if (w_empty) begin
        mem_resp_ready = 1'b1;
      end else begin
        imem_resp_valid = mem_resp_valid && !w_head;
        dmem_resp_valid = mem_resp_valid && w_head;
        mem_resp_ready  = w_head ? dmem_resp_ready : imem_resp_ready;
      end
    end
    w_resp_fire = mem_resp_valid && mem_resp_ready && !w_empty;
  end

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    rr_last_d  = rr_last_q;
    err_d      = err_q | (mem_resp_valid && w_empty);
    owner_d    = owner_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    case (state_q)
      ST_ARB: begin
        if (w_req_valid && !mem_req_ready) begin
          state_d    = ST_HOLD;
          lock_sel_d = w_sel;
        end
      end
      ST_HOLD: begin
        if (w_req_fire) begin
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
    if (w_req_fire) begin
      rr_last_d         = w_sel;
      owner_d[wr_ptr_q] = w_sel;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (w_resp_fire) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({w_req_fire, w_resp_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // rr_last resets to dmem so the first contended grant goes to imem.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_ARB;
      lock_sel_q <= 1'b0;
      rr_last_q  <= 1'b1;
      err_q      <= 1'b0;
      owner_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      rr_last_q  <= rr_last_d;
      err_q      <= err_d;
      owner_q    <= owner_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign outstanding = count_q;
  assign err_resp    = err_q;

endmodule
`default_nettype wire
